dma_burst_device: RTL



---
 rtl/dma_burst_device.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dma_burst_device.sv
// Clocked external device model: holds a batch of burst-wide blocks, requests a DMA transfer
// with a timed interrupt, serves offset-addressed burst reads, then refills and re-arms.
module dma_burst_device #(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned BURST_WORDS = 4,
    parameter int unsigned NUM_BLOCKS  = 3,
    parameter int unsigned OFFSET_BITS = 2,
    parameter int unsigned FIRE_DELAY  = 1891,
    parameter int unsigned INT_CYCLES  = 10,
    parameter int unsigned NUM_BATCHES = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [OFFSET_BITS-1:0]          offset,
    input  logic                            rd_en,
    input  logic                            intr_ack,
    input  logic                            done,
    output logic                            interrupt,
    output logic [BURST_WORDS*WORD_SIZE-1:0] data,
    output logic                            data_valid,
    output logic                            err,
    output logic                            busy
);

    localparam int unsigned DataW  = BURST_WORDS * WORD_SIZE;
    localparam int unsigned MaxCnt = (FIRE_DELAY > INT_CYCLES) ? FIRE_DELAY : INT_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam logic [CntW-1:0] FireLast = CntW'(FIRE_DELAY - 1);
    localparam logic [CntW-1:0] IntLast  = CntW'(INT_CYCLES - 1);

    typedef enum logic [2:0] {
        StWait,
        StReq,
        StServe,
        StDone,
        StHalt
    } state_e;

    // Word w of block b in batch n is {n, b[3:0], w[3:0]}, zero-extended.
    function automatic logic [DataW-1:0] block_pattern(input logic [7:0] n,
                                                       input int unsigned b);
        logic [DataW-1:0] blk;
        blk = '0;
        for (int unsigned w = 0; w < BURST_WORDS; w++) begin
            blk[w*WORD_SIZE +: WORD_SIZE] = WORD_SIZE'({n, 4'(b), 4'(w)});
        end
        return blk;
    endfunction

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [7:0]       batch_q, batch_d;
    logic [DataW-1:0] data_q, data_d;
    logic             dv_q, dv_d;
    logic             err_q, err_d;
    logic             reload;
    logic             offset_ok;
    logic [DataW-1:0] mem_q [NUM_BLOCKS];

    assign offset_ok = 32'(offset) < NUM_BLOCKS;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        batch_d = batch_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        err_d   = 1'b0;
        reload  = 1'b0;
        unique case (state_q)
            StWait: begin
                if (cnt_q == FireLast) begin
                    state_d = StReq;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StReq: begin
                // An ack on the final timeout cycle still wins.
                if (intr_ack) begin
                    state_d = StServe;
                    cnt_d   = '0;
                end else if (cnt_q == IntLast) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StServe: begin
                if (rd_en) begin
                    if (offset_ok) begin
                        data_d = mem_q[offset];
                        dv_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (done) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                batch_d = batch_q + 8'd1;
                reload  = 1'b1;
                cnt_d   = '0;
                if ((NUM_BATCHES != 0) && (batch_d == 8'(NUM_BATCHES))) begin
                    state_d = StHalt;
                end else begin
                    state_d = StWait;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StWait;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StWait;
            cnt_q   <= '0;
            batch_q <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
            for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
                mem_q[b] <= block_pattern(8'd0, b);
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            batch_q <= batch_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
            if (reload) begin
                for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
                    mem_q[b] <= block_pattern(batch_d, b);
                end
            end
        end
    end

    // Status outputs decode the registered state, so no input reaches them combinationally.
    assign interrupt  = (state_q == StReq);
    assign busy       = (state_q == StServe);
    assign data       = data_q;
    assign data_valid = dv_q;
    assign err        = err_q;

endmodule
